// File: rtl/fetch_queue_if.sv
// fetch_queue_if
//   Bundles the two handshakes around the fetch queue:
//   - memory side: request (valid/addr/ready) and in-order response (valid/data)
//   - consumer side: queue head (valid/instr/pc) with ready from decode
//   master : the fetch queue itself
//   slave  : instruction memory plus consumer (decode stage or testbench)
interface fetch_queue_if;
   logic        mem_req_valid;
   logic [63:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic        out_ready;

   modport master (
      output mem_req_valid, mem_req_addr, out_valid, out_instr, out_pc,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready
   );

   modport slave (
      input  mem_req_valid, mem_req_addr, out_valid, out_instr, out_pc,
      output mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction fetch front end. Issues sequential word fetches to a
//   variable-latency memory, buffers returned words with their PCs in an
//   in-order queue, and presents the head to decode. A redirect flushes the
//   queue and marks every still-outstanding fetch as stale so its response
//   is dropped on arrival.
// Ports
//   CLK          clock, all state on rising edge
//   resetl       synchronous active-low reset
//   startpc      fetch PC loaded while in reset
//   redirect     branch/jump flush request
//   redirect_pc  new fetch PC (low two bits forced to zero)
//   fq           fetch_queue_if.master: memory request/response, queue head
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic          CLK,
   input  logic          resetl,
   input  logic [63:0]   startpc,
   input  logic          redirect,
   input  logic [63:0]   redirect_pc,
   fetch_queue_if.master fq
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = DEPTH[CNT_W-1:0];
   localparam logic [CNT_W:0]   DEPTH_W = DEPTH[CNT_W:0];

   logic [63:0]      fetch_pc_q, fetch_pc_d;
   logic [63:0]      rsp_pc_q, rsp_pc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] inflight_q, inflight_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

   logic [31:0] instr_mem_q [DEPTH];
   logic [63:0] pc_mem_q    [DEPTH];

   logic [CNT_W:0]   used;
   logic             req_valid;
   logic             req_fire;
   logic             rsp_take;
   logic             rsp_drop;
   logic             push;
   logic             head_valid;
   logic             pop;
   logic [CNT_W-1:0] inflight_after_rsp;

   // Credit covers both buffered and outstanding words, so every response
   // that is not dropped is guaranteed a free slot.
   assign used = {1'b0, count_q} + {1'b0, inflight_q};

   always_comb begin
      req_valid          = resetl && !redirect && (used < DEPTH_W);
      req_fire           = req_valid && fq.mem_req_ready;
      rsp_take           = resetl && fq.mem_rsp_valid;
      rsp_drop           = rsp_take && (drop_cnt_q != '0);
      push               = rsp_take && !rsp_drop && !redirect;
      head_valid         = resetl && (count_q != '0);
      pop                = head_valid && fq.out_ready && !redirect;
      inflight_after_rsp = inflight_q - CNT_W'(rsp_take);

      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      count_d    = count_q;
      inflight_d = inflight_after_rsp;
      drop_cnt_d = drop_cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;

      if (redirect) begin
         fetch_pc_d = redirect_pc & ~64'd3;
         rsp_pc_d   = redirect_pc & ~64'd3;
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         // Everything still outstanding after this cycle's response is stale,
         // which also absorbs any drops that were already pending.
         drop_cnt_d = inflight_after_rsp;
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 64'd4;
         end
         inflight_d = inflight_after_rsp + CNT_W'(req_fire);
         if (rsp_drop) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
         end
         if (push) begin
            rsp_pc_d = rsp_pc_q + 64'd4;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge CLK) begin
      if (!resetl) begin
         fetch_pc_q <= startpc;
         rsp_pc_q   <= startpc;
         count_q    <= '0;
         inflight_q <= '0;
         drop_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         drop_cnt_q <= drop_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Storage needs no reset: the head is masked whenever the queue is empty.
   always_ff @(posedge CLK) begin
      if (push) begin
         instr_mem_q[wr_ptr_q] <= fq.mem_rsp_data;
         pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
      end
   end

   assign fq.mem_req_valid = req_valid;
   assign fq.mem_req_addr  = resetl ? fetch_pc_q : '0;
   assign fq.out_valid     = head_valid;
   assign fq.out_instr     = head_valid ? instr_mem_q[rd_ptr_q] : '0;
   assign fq.out_pc        = head_valid ? pc_mem_q[rd_ptr_q] : '0;

   a_no_push_when_full : assert property (@(posedge CLK) disable iff (!resetl)
      push |-> (count_q != DEPTH_C));

   a_no_rsp_underflow : assert property (@(posedge CLK) disable iff (!resetl)
      fq.mem_rsp_valid |-> (inflight_q != '0));

endmodule
